// File: rtl/memwb_skid_reg.sv
// MEM/WB elastic pipeline register: valid/ready handshake over a main + skid entry,
// synchronous flush, and write-enable gating so bubbles never write the register file.
module memwb_skid_reg #(
  parameter int DATA_W        = 32,
  parameter int REG_W         = 5,
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [REG_W-1:0]  mdestReg,
  input  logic [DATA_W-1:0] mr,
  input  logic [DATA_W-1:0] mdo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [REG_W-1:0]  wdestReg,
  output logic [DATA_W-1:0] wr,
  output logic [DATA_W-1:0] wdo,
  output logic [DATA_W-1:0] wdata,
  output logic [1:0]        occ
);

  localparam int FW = 2 + REG_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [FW-1:0]   r_main;
  logic [FW-1:0]   r_skid;
  logic [FW-1:0]   w_in_fields;
  logic            w_accept;
  logic            w_main_valid;
  logic            w_skid_valid;
  logic            w_load_main_in;
  logic            w_load_main_skid;
  logic            w_load_skid;
  logic            w_main_wreg;
  logic            w_main_m2reg;
  logic            w_dest_is_zero;

  assign w_in_fields  = {mwreg, mm2reg, mdestReg, mr, mdo};
  assign w_main_valid = (r_state != S_EMPTY);
  assign w_skid_valid = (r_state == S_FULL);
  assign in_ready     = ~w_skid_valid;
  assign w_accept     = in_valid & in_ready;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_next = S_ONE;
      S_ONE: begin
        if (w_accept && !out_ready)      w_state_next = S_FULL;
        else if (!w_accept && out_ready) w_state_next = S_EMPTY;
      end
      S_FULL:  if (out_ready) w_state_next = S_ONE;
      default: w_state_next = S_EMPTY;
    endcase
    if (flush) w_state_next = S_EMPTY;
  end

  // Datapath load controls
  always_comb begin
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (!flush) begin
      case (r_state)
        S_EMPTY: w_load_main_in = w_accept;
        S_ONE: begin
          w_load_main_in = w_accept & out_ready;
          w_load_skid    = w_accept & ~out_ready;
        end
        S_FULL:  w_load_main_skid = out_ready;
        default: ;
      endcase
    end
  end

  // Payload is only qualified by the state, so it is left stale on drain/flush
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in)        r_main <= w_in_fields;
      else if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= w_in_fields;
    end
  end

  assign {w_main_wreg, w_main_m2reg, wdestReg, wr, wdo} = r_main;
  assign w_dest_is_zero = (wdestReg == '0);

  assign out_valid = w_main_valid;
  assign wwreg     = w_main_valid & w_main_wreg & ~(ZERO_SUPPRESS & w_dest_is_zero);
  assign wm2reg    = w_main_valid & w_main_m2reg;
  assign wdata     = wm2reg ? wdo : wr;
  assign occ       = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule

// File: tb/tb_memwb_skid_reg.sv
// Directed bench for memwb_skid_reg: streaming, backpressure, flush, zero suppression,
// writeback mux and asynchronous reset while full.
module tb_memwb_skid_reg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clock;
  logic              resetn;
  logic              in_valid;
  logic              flush;
  logic              mwreg;
  logic              mm2reg;
  logic [REG_W-1:0]  mdestReg;
  logic [DATA_W-1:0] mr;
  logic [DATA_W-1:0] mdo;
  logic              out_ready;

  logic              in_ready, out_valid, wwreg, wm2reg;
  logic [REG_W-1:0]  wdestReg;
  logic [DATA_W-1:0] wr, wdo, wdata;
  logic [1:0]        occ;

  logic              nz_in_ready, nz_out_valid, nz_wwreg, nz_wm2reg;
  logic [REG_W-1:0]  nz_wdestReg;
  logic [DATA_W-1:0] nz_wr, nz_wdo, nz_wdata;
  logic [1:0]        nz_occ;

  int checks = 0;
  int errors = 0;

  memwb_skid_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .ZERO_SUPPRESS(1'b1)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .mwreg(mwreg), .mm2reg(mm2reg), .mdestReg(mdestReg),
    .mr(mr), .mdo(mdo), .out_valid(out_valid), .out_ready(out_ready),
    .wwreg(wwreg), .wm2reg(wm2reg), .wdestReg(wdestReg), .wr(wr), .wdo(wdo),
    .wdata(wdata), .occ(occ)
  );

  memwb_skid_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .ZERO_SUPPRESS(1'b0)) dut_nz (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(nz_in_ready),
    .flush(flush), .mwreg(mwreg), .mm2reg(mm2reg), .mdestReg(mdestReg),
    .mr(mr), .mdo(mdo), .out_valid(nz_out_valid), .out_ready(out_ready),
    .wwreg(nz_wwreg), .wm2reg(nz_wm2reg), .wdestReg(nz_wdestReg), .wr(nz_wr),
    .wdo(nz_wdo), .wdata(nz_wdata), .occ(nz_occ)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wreg, input logic m2r,
                       input logic [REG_W-1:0] dest, input logic [DATA_W-1:0] r,
                       input logic [DATA_W-1:0] d);
    in_valid = v;
    mwreg    = wreg;
    mm2reg   = m2r;
    mdestReg = dest;
    mr       = r;
    mdo      = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occ, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wwreg", wwreg, 0);
    chk("rst_wdata", wdata, 0);
    #10 resetn = 1'b1;
    tick();
    chk("idle_occ", occ, 0);

    // Streaming with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'd8, 32'h10 + i, 32'h0);
      tick();
      chk($sformatf("stream_valid_%0d", i), out_valid, 1);
      chk($sformatf("stream_wr_%0d", i), wr, 32'h10 + i);
      chk($sformatf("stream_wwreg_%0d", i), wwreg, 1);
      chk($sformatf("stream_occ_%0d", i), occ, 1);
    end
    chk("stream_dest", wdestReg, 8);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_wwreg", wwreg, 0);
    chk("drain_occ", occ, 0);

    // Backpressure: A in main, B goes to skid, E must be refused while full
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hA, 32'h0);
    tick();
    chk("bp_one_occ", occ, 1);
    chk("bp_one_wr", wr, 32'hA);
    chk("bp_one_ready", in_ready, 1);
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hB, 32'h0);
    tick();
    chk("bp_full_occ", occ, 2);
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_wr", wr, 32'hA);
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hE, 32'h0);
    tick();
    chk("bp_hold_occ", occ, 2);
    chk("bp_hold_wr", wr, 32'hA);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    out_ready = 1'b1;
    tick();
    chk("bp_pop_occ", occ, 1);
    chk("bp_pop_wr", wr, 32'hB);
    chk("bp_pop_ready", in_ready, 1);
    tick();
    chk("bp_empty_valid", out_valid, 0);
    chk("bp_empty_occ", occ, 0);

    // Flush while full, with a valid input presented
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h21, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h22, 32'h0);
    tick();
    chk("fl_full_occ", occ, 2);
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'hC, 32'h0);
    flush = 1'b1;
    tick();
    chk("fl_full_occ0", occ, 0);
    chk("fl_full_valid", out_valid, 0);
    chk("fl_full_wwreg", wwreg, 0);
    chk("fl_full_ready", in_ready, 1);

    // Flush while EMPTY drops an input that would otherwise be accepted
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'hC, 32'h0);
    tick();
    chk("fl_drop_occ", occ, 0);
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    out_ready = 1'b1;
    tick();
    chk("fl_after_valid", out_valid, 0);
    chk("fl_after_occ", occ, 0);

    // Zero-register suppression
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 32'h0);
    tick();
    chk("zs_on_wwreg", wwreg, 0);
    chk("zs_off_wwreg", nz_wwreg, 1);
    chk("zs_valid", out_valid, 1);
    drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h56, 32'h0);
    tick();
    chk("zs_on_nonzero", wwreg, 1);
    chk("zs_off_nonzero", nz_wwreg, 1);

    // Writeback mux
    drive(1'b1, 1'b1, 1'b1, 5'd5, 32'h1234, 32'hDEADBEEF);
    tick();
    chk("mux_mem", wdata, 32'hDEADBEEF);
    chk("mux_wm2reg", wm2reg, 1);
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'hDEADBEEF);
    tick();
    chk("mux_alu", wdata, 32'h1234);
    chk("mux_wm2reg0", wm2reg, 0);
    drive(1'b0, 1'b1, 1'b1, 5'd5, 32'h1234, 32'hDEADBEEF);
    tick();
    chk("bubble_wwreg", wwreg, 0);
    chk("bubble_wm2reg", wm2reg, 0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h31, 32'h41);
    tick();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h32, 32'h42);
    tick();
    chk("rf_occ", occ, 2);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #2 resetn = 1'b0;
    #1;
    chk("rf_valid", out_valid, 0);
    chk("rf_occ0", occ, 0);
    chk("rf_ready", in_ready, 1);
    chk("rf_wwreg", wwreg, 0);
    chk("rf_wm2reg", wm2reg, 0);
    chk("rf_wr", wr, 0);
    chk("rf_wdo", wdo, 0);
    chk("rf_dest", wdestReg, 0);
    chk("rf_wdata", wdata, 0);
    #2 resetn = 1'b1;

    // First accept after release
    drive(1'b1, 1'b1, 1'b0, 5'd2, 32'h77, 32'h0);
    tick();
    chk("rel_valid", out_valid, 1);
    chk("rel_wr", wr, 32'h77);
    chk("rel_occ", occ, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memwb_skid_reg.md
# memwb_skid_reg

Parametrised, elastic MEM/WB pipeline register for the 5-stage MIPS core. It replaces the free-running stage latch with a valid/ready handshake backed by a 2-entry skid buffer, which gives full throughput under backpressure. It also provides synchronous flush and bubble-safe gating of the register-write control, so an empty or flushed slot can never write the register file. It sits between the data-memory stage and the writeback mux/register file, and also presents the selected writeback value.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and memory read data
- REG_W, 5, width of destination register index
- ZERO_SUPPRESS, 1, when 1, wwreg is forced low if wdestReg == 0 (MIPS $zero)

Ports:
- clock  input  1  single clock, rising edge
- resetn  input  1  asynchronous, active-low reset
- in_valid  input  1  MEM stage presents a valid instruction
- in_ready  output  1  stage can accept; transfer when in_valid & in_ready
- flush  input  1  synchronous kill of all held entries and of the current input
- mwreg  input  1  register-write enable from MEM
- mm2reg  input  1  select memory data for writeback
- mdestReg  input  REG_W  destination register
- mr  input  DATA_W  ALU result
- mdo  input  DATA_W  memory read data
- out_valid  output  1  WB slot holds a valid instruction
- out_ready  input  1  WB consumes; transfer when out_valid & out_ready
- wwreg  output  1  gated register-write enable
- wm2reg, wdestReg, wr, wdo  output  1/REG_W/DATA_W/DATA_W  registered copies of the MEM fields
- wdata  output  DATA_W  wm2reg ? wdo : wr (combinational from registered fields)
- occ  output  2  entries held (0, 1, 2)

## Operation
- Storage: main register (drives outputs) plus skid register; each has a valid bit and a full field set.
- States: EMPTY (occ=0), ONE (main valid), FULL (main+skid valid).
- in_ready = ~skid_valid; it is registered state, with no combinational path from out_ready.
- out_valid = main_valid.
- EMPTY: accept -> load main, go to ONE.
- ONE, accept & out_ready: main reloaded with new input, stay ONE.
- ONE, accept & ~out_ready: input to skid, go FULL.
- ONE, no accept & out_ready: go EMPTY.
- ONE, otherwise: hold.
- FULL: no accept possible. out_ready -> main <= skid, go ONE; else hold.
- flush has highest priority. Next edge: both valid bits clear, go EMPTY, and the input presented that cycle is dropped even if in_valid & in_ready.
- wwreg = main_valid & main_wreg & ~(ZERO_SUPPRESS & wdestReg == 0). wm2reg is gated by main_valid the same way.
- Data fields are not cleared on drain or flush; only valid and the gated controls matter.
- occ = main_valid + skid_valid.

## Timing
- Reset (resetn low, asynchronous): state EMPTY. out_valid=0, wwreg=0, wm2reg=0, wdestReg=0, wr=0, wdo=0, wdata=0, occ=0, in_ready=1. This holds mid-operation and discards any held entries.
- Reset release: the first accept can occur on the first rising edge with resetn high.
- Latency: 1 cycle from accepting edge to out_valid when the stage was EMPTY or draining.
- Throughput: 1 instruction/cycle while out_ready stays high.
- Backpressure: the first stalled cycle still accepts one instruction into skid. in_ready falls the cycle after.
- Ordering: strictly FIFO; skid never overtakes main.
- Simultaneous flush and out_ready: the main entry is still consumed that cycle by WB, then EMPTY.
- Simultaneous flush and resetn low: reset wins.

## Test plan
- Reset mid-FULL: fill both entries, pull resetn low between edges -> outputs immediately 0, occ=0, in_ready=1.
- Streaming: out_ready=1, feed (mwreg=1, mdestReg=8, mr=0x10+i) for i=0..7 -> one output per cycle, 1-cycle latency, wr=0x10..0x17 in order, wwreg=1 each cycle.
- Backpressure: ONE holding mr=0xA, out_ready=0, input mr=0xB -> occ=2, in_ready=0 next cycle. Raise out_ready -> outputs 0xA then 0xB, no loss or duplicate.
- Flush in FULL with in_valid=1 (mr=0xC) -> next cycle occ=0, out_valid=0, wwreg=0. 0xC never appears.
- Zero suppression: mwreg=1, mdestReg=0 -> wwreg=0 with ZERO_SUPPRESS=1, wwreg=1 with ZERO_SUPPRESS=0.
- Writeback mux: mm2reg=1, mdo=0xDEADBEEF, mr=0x1234 -> wdata=0xDEADBEEF. With mm2reg=0 -> wdata=0x1234.
